phy_rcv_nibble: RTL and testbench
=================================

// Module: phy_rcv_nibble
// PURPOSE
//  Receive-side counterpart of the transmit PHY path. Accepts the 4-bit MII-style
//  nibble stream (phy_rx_dv/phy_rx_er/phy_data_in) and strips preamble/SFD.
//  Packs nibbles into bytes, checks FCS and length, and emits a byte stream
//  plus one 24-bit control block per frame (f_data_out/f_ctrl_out).
//  Sits between the PHY pins and the receive buffer/queue logic; single clock domain (clk_phy).
// PARAMETERS
//  MIN_PRE   4     min count of 0x5 preamble nibbles before SFD nibble 0xD
//  MIN_LEN   64    min frame bytes (DA..FCS inclusive); shorter -> runt
//  MAX_LEN   1518  max frame bytes; longer -> long, extra bytes not forwarded
//  LEN_W     12    width of length field in ctrl block
// PORTS
//  clk_phy       in   1   PHY clock; all logic on rising edge
//  reset         in   1   asynchronous, active-low reset
//  phy_rx_dv     in   1   receive data valid
//  phy_rx_er     in   1   receive error; sampled only while phy_rx_dv=1
//  phy_data_in   in   4   receive nibble, low nibble of each byte first
//  f_data_out    out  8   assembled frame byte
//  f_data_valid  out  1   1-cycle strobe, f_data_out valid
//  f_sof         out  1   high with f_data_valid on first byte of frame
//  f_ctrl_out    out  24  per-frame control block, held until next frame end
//  f_frame_valid out  1   1-cycle strobe, f_ctrl_out updated this cycle
//  f_frame_ok    out  1   with f_frame_valid: f_ctrl_out[4:0]==0
// BEHAVIOUR
//  Reset (async assert, sync deassert upstream): all outputs 0, state IDLE, counters/CRC cleared.
//  FSM:
//   IDLE:     dv=1 & nib=5 -> PRE (pre_cnt=1); else stay.
//   PRE:      dv=0 -> IDLE, silent.
//             nib=5 -> pre_cnt++ (saturate).
//             nib=D & pre_cnt>=MIN_PRE -> DATA (phase=0, len=0, CRC=all-ones).
//             Any other nibble -> DROP.
//   DATA:     phase=0: latch low nibble. phase=1: {nib,low} forms byte.
//             Byte registered to f_data_out; f_data_valid=1 next cycle (latency 1 from high nibble).
//             len++ per byte, saturating at 2^LEN_W-1.
//             Bytes with len>=MAX_LEN are not strobed; long flag set.
//             dv=0 -> END.
//   END:      1 cycle; f_frame_valid=1, f_ctrl_out loaded -> IDLE.
//             If dv=1 & nib=5 in this cycle, go directly to PRE (back-to-back frames).
//   DROP:     wait for dv=0 -> IDLE; no strobes, no ctrl block.
//  Throughput: max one byte strobe per 2 cycles.
//  CRC: CRC-32 (poly 04C11DB7, reflected, init FFFFFFFF) over every byte incl. FCS.
//   Good frame iff residue == C704DD7B. Updated only for bytes with len<MAX_LEN.
//  Ctrl block f_ctrl_out:
//   [23:12] len     byte count
//   [11:5]  0
//   [4]     rx_er   phy_rx_er seen in DATA
//   [3]     long    len>MAX_LEN
//   [2]     runt    len<MIN_LEN
//   [1]     odd     phase=1 at dv fall; trailing nibble dropped
//   [0]     crc_err
//  Zero-byte frame (SFD then dv=0): ctrl len=0, runt=1, crc_err=1.
//  Reset mid-frame: frame abandoned immediately; no f_frame_valid for it.
// STRUCTURE
//  Shared include xlit_defs.vh:
//   ctrl bit positions, CTRL_LEN_MSB/LSB, PRE_NIB=4'h5, SFD_NIB=4'hD, CRC_RESIDUE=32'hC704DD7B.
//   Same file used by transmit path to build/parse ctrl blocks.
//  Sub-module crc32_d8: combinational next-CRC for 8-bit data. Shared with the transmit FCS generator.
//  Top holds FSM, nibble packer, length counter, flag regs.
// TESTING
//  1 Preamble 15x5 + D, 64-byte frame with valid FCS:
//    64 f_data_valid strobes, f_sof on byte 0, ctrl=24'h040000, f_frame_ok=1.
//  2 Same frame, one payload bit flipped:
//    ctrl=24'h040001, f_frame_ok=0; all bytes still strobed.
//  3 Frame of 40 bytes + odd trailing nibble -> ctrl=24'h028007 (len=40, runt, odd, crc_err).
//  4 1600-byte frame -> exactly 1518 strobes, ctrl[23:12]=1600 (0x640), long=1.
//  5 Preamble 3x5 + D (MIN_PRE=4) then data: DROP, no strobes, no f_frame_valid.
//    Next frame after dv=0 received normally.
//  6 reset low mid-DATA (byte 20): outputs 0 within same cycle, no ctrl strobe.
//    Back-to-back frames with 1-cycle dv gap: two f_frame_valid strobes, both f_frame_ok=1.

Source files
------------

// File: rtl/phy_rcv_nibble_pkg.sv
// Receive PHY nibble path: shared constants,
// ctrl block layout and FSM state encoding.
package phy_rcv_nibble_pkg;

  localparam int DEF_MIN_PRE = 4;
  localparam int DEF_MIN_LEN = 64;
  localparam int DEF_MAX_LEN = 1518;
  localparam int DEF_LEN_W   = 12;
  localparam int PRE_W       = 4;

  localparam int CTRL_W       = 24;
  localparam int CTRL_LEN_MSB = 23;
  localparam int CTRL_LEN_LSB = 12;
  localparam int CTRL_RXER    = 4;
  localparam int CTRL_LONG    = 3;
  localparam int CTRL_RUNT    = 2;
  localparam int CTRL_ODD     = 1;
  localparam int CTRL_CRC     = 0;

  localparam logic [3:0]  PRE_NIB     = 4'h5;
  localparam logic [3:0]  SFD_NIB     = 4'hD;
  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_END,
    ST_DROP
  } rx_state_e;

  // The shift register runs LSB-first, so the residue
  // constant is compared in bit-reversed order.
  function automatic logic [31:0] rev32(
    input logic [31:0] v
  );
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/phy_rcv_nibble_crc32_d8.sv
// Combinational next-state of the reflected
// CRC-32 register for one data byte.
module crc32_d8
  import phy_rcv_nibble_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  // Eight LSB-first shift steps of the reflected poly.
  always_comb begin
    c = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_i[i]) begin
        c = (c >> 1) ^ CRC_POLY_R;
      end else begin
        c = c >> 1;
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/phy_rcv_nibble.sv
// MII nibble receiver: preamble/SFD strip, byte
// packing, FCS and length checks, ctrl block.
module phy_rcv_nibble
  import phy_rcv_nibble_pkg::*;
#(
  parameter int MIN_PRE = DEF_MIN_PRE,
  parameter int MIN_LEN = DEF_MIN_LEN,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic              clk_phy,
  input  logic              reset,
  input  logic              phy_rx_dv,
  input  logic              phy_rx_er,
  input  logic [3:0]        phy_data_in,
  output logic [7:0]        f_data_out,
  output logic              f_data_valid,
  output logic              f_sof,
  output logic [CTRL_W-1:0] f_ctrl_out,
  output logic              f_frame_valid,
  output logic              f_frame_ok
);

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [PRE_W-1:0] PRE_L = PRE_W'(MIN_PRE);

  rx_state_e         state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic              phase_q, phase_d;
  logic [3:0]        low_q, low_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       crc_q, crc_d;
  logic              er_q, er_d;
  logic [7:0]        data_q, data_d;
  logic              dval_q, dval_d;
  logic              sof_q, sof_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              fval_q, fval_d;
  logic              fok_q, fok_d;

  logic [31:0]       crc_nx;
  logic [7:0]        byte_c;
  logic [4:0]        flags_c;

  assign byte_c = {phy_data_in, low_q};

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (byte_c),
    .crc_o  (crc_nx)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk_phy or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      phase_q <= 1'b0;
      low_q   <= '0;
      len_q   <= '0;
      crc_q   <= '0;
      er_q    <= 1'b0;
      data_q  <= '0;
      dval_q  <= 1'b0;
      sof_q   <= 1'b0;
      ctrl_q  <= '0;
      fval_q  <= 1'b0;
      fok_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      phase_q <= phase_d;
      low_q   <= low_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      er_q    <= er_d;
      data_q  <= data_d;
      dval_q  <= dval_d;
      sof_q   <= sof_d;
      ctrl_q  <= ctrl_d;
      fval_q  <= fval_d;
      fok_q   <= fok_d;
    end
  end

  // Next-state: FSM, nibble packer, length and flags.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    phase_d = phase_q;
    low_d   = low_q;
    len_d   = len_q;
    crc_d   = crc_q;
    er_d    = er_q;
    data_d  = data_q;
    dval_d  = 1'b0;
    sof_d   = 1'b0;
    ctrl_d  = ctrl_q;
    fval_d  = 1'b0;
    fok_d   = 1'b0;
    flags_c = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (phy_rx_dv && phy_data_in == PRE_NIB) begin
          state_d = ST_PRE;
          pre_d   = PRE_W'(1);
        end
      end
      ST_PRE: begin
        if (!phy_rx_dv) begin
          state_d = ST_IDLE;
        end else if (phy_data_in == PRE_NIB) begin
          if (pre_q != '1) begin
            pre_d = pre_q + PRE_W'(1);
          end
        end else if (phy_data_in == SFD_NIB
                     && pre_q >= PRE_L) begin
          state_d = ST_DATA;
          phase_d = 1'b0;
          len_d   = '0;
          crc_d   = CRC_INIT;
          er_d    = 1'b0;
        end else begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!phy_rx_dv) begin
          flags_c[CTRL_RXER] = er_q;
          flags_c[CTRL_LONG] = len_q > MAX_L;
          flags_c[CTRL_RUNT] = len_q < MIN_L;
          flags_c[CTRL_ODD]  = phase_q;
          flags_c[CTRL_CRC]  =
            rev32(crc_q) != CRC_RESIDUE;
          ctrl_d = '0;
          ctrl_d[CTRL_LEN_MSB:CTRL_LEN_LSB] = len_q;
          ctrl_d[4:0] = flags_c;
          fval_d  = 1'b1;
          fok_d   = flags_c == '0;
          state_d = ST_END;
        end else begin
          er_d = er_q | phy_rx_er;
          if (!phase_q) begin
            low_d   = phy_data_in;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (len_q < MAX_L) begin
              data_d = byte_c;
              dval_d = 1'b1;
              sof_d  = len_q == '0;
              crc_d  = crc_nx;
            end
            if (len_q != '1) begin
              len_d = len_q + LEN_W'(1);
            end
          end
        end
      end
      ST_END: begin
        if (phy_rx_dv && phy_data_in == PRE_NIB) begin
          state_d = ST_PRE;
          pre_d   = PRE_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!phy_rx_dv) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign f_data_out    = data_q;
  assign f_data_valid  = dval_q;
  assign f_sof         = sof_q;
  assign f_ctrl_out    = ctrl_q;
  assign f_frame_valid = fval_q;
  assign f_frame_ok    = fok_q;

endmodule

// File: tb/tb_phy_rcv_nibble.sv
// Randomized bench for phy_rcv_nibble against a
// frame-level reference model.
module tb_phy_rcv_nibble;

  logic        clk_phy = 1'b0;
  logic        reset;
  logic        phy_rx_dv;
  logic        phy_rx_er;
  logic [3:0]  phy_data_in;
  logic [7:0]  f_data_out;
  logic        f_data_valid;
  logic        f_sof;
  logic [23:0] f_ctrl_out;
  logic        f_frame_valid;
  logic        f_frame_ok;

  int n_run = 0;
  int n_bad = 0;

  logic [7:0]  tx [0:2047];
  logic [7:0]  rxq [$];
  int          sofq [$];
  logic [23:0] fq [$];
  logic        okq [$];

  always #5 clk_phy = ~clk_phy;

  phy_rcv_nibble dut (
    .clk_phy       (clk_phy),
    .reset         (reset),
    .phy_rx_dv     (phy_rx_dv),
    .phy_rx_er     (phy_rx_er),
    .phy_data_in   (phy_data_in),
    .f_data_out    (f_data_out),
    .f_data_valid  (f_data_valid),
    .f_sof         (f_sof),
    .f_ctrl_out    (f_ctrl_out),
    .f_frame_valid (f_frame_valid),
    .f_frame_ok    (f_frame_ok)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(posedge clk_phy) begin
    #1;
    if (f_data_valid) begin
      if (f_sof) sofq.push_back(rxq.size());
      rxq.push_back(f_data_out);
    end
    if (f_frame_valid) begin
      fq.push_back(f_ctrl_out);
      okq.push_back(f_frame_ok);
    end
  end

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  b
  );
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [31:0] crc_over(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = crc_byte(c, tx[i]);
    return c;
  endfunction

  // Ctrl block from the frame rules: length, flags and
  // FCS check over the bytes that were not discarded.
  function automatic logic [23:0] exp_ctrl(
    input int n, input bit odd, input bit er
  );
    logic [23:0] r = '0;
    int          kept = (n > 1518) ? 1518 : n;
    r[23:12] = (n > 4095) ? 12'hFFF : 12'(n);
    r[4] = er;
    r[3] = n > 1518;
    r[2] = n < 64;
    r[1] = odd;
    r[0] = crc_over(kept) != 32'hDEBB20E3;
    return r;
  endfunction

  task automatic fill(input int n, input bit fcs);
    logic [31:0] f;
    for (int i = 0; i <= n; i++) tx[i] = 8'($urandom);
    if (fcs && n >= 4) begin
      f = ~crc_over(n - 4);
      for (int i = 0; i < 4; i++) tx[n-4+i] = f[8*i +: 8];
    end
  endtask

  task automatic drv(
    input bit dv, input bit er, input logic [3:0] nib
  );
    @(negedge clk_phy);
    phy_rx_dv   = dv;
    phy_rx_er   = er;
    phy_data_in = nib;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 4'h0);
  endtask

  // Preamble, SFD, nb bytes low nibble first, optional
  // trailing nibble, then one dv-low cycle.
  task automatic send(
    input int pre, input int nb,
    input bit odd, input int er_nib
  );
    logic [7:0] b;
    for (int i = 0; i < pre; i++) drv(1, 0, 4'h5);
    drv(1, 0, 4'hD);
    for (int k = 0; k < 2 * nb + int'(odd); k++) begin
      b = tx[k/2];
      drv(1, k == er_nib, (k % 2) ? b[7:4] : b[3:0]);
    end
    drv(0, 0, 4'h0);
  endtask

  task automatic clear_q();
    rxq.delete();
    sofq.delete();
    fq.delete();
    okq.delete();
  endtask

  task automatic check_frame(
    input string tag, input int n, input logic [23:0] ec
  );
    int ns = (n > 1518) ? 1518 : n;
    int errs = 0;
    idle(4);
    chk({tag, ".nbytes"}, rxq.size(), ns);
    for (int i = 0; i < rxq.size() && i < ns; i++) begin
      if (rxq[i] !== tx[i]) errs++;
    end
    chk({tag, ".data"}, errs, 0);
    chk({tag, ".nsof"}, sofq.size(), (ns > 0) ? 1 : 0);
    if (sofq.size() > 0) chk({tag, ".sofpos"}, sofq[0], 0);
    chk({tag, ".nframe"}, fq.size(), 1);
    if (fq.size() > 0) begin
      chk({tag, ".ctrl"}, fq[0], ec);
      chk({tag, ".ok"}, okq[0], ec[4:0] == 5'd0);
    end
    clear_q();
  endtask

  initial begin
    int n, pre, en;
    bit odd, good;
    logic [23:0] ec;

    reset = 1'b0;
    phy_rx_dv = 1'b0;
    phy_rx_er = 1'b0;
    phy_data_in = 4'h0;
    repeat (3) @(negedge clk_phy);
    chk("rst.data", f_data_out, 0);
    chk("rst.dval", f_data_valid, 0);
    chk("rst.sof", f_sof, 0);
    chk("rst.ctrl", f_ctrl_out, 0);
    chk("rst.fval", f_frame_valid, 0);
    chk("rst.ok", f_frame_ok, 0);
    reset = 1'b1;
    idle(2);

    fill(64, 1);
    send(15, 64, 0, -1);
    check_frame("good64", 64, 24'h040000);

    fill(64, 1);
    tx[10] = tx[10] ^ 8'h04;
    send(15, 64, 0, -1);
    check_frame("flip64", 64, 24'h040001);

    fill(40, 0);
    send(7, 40, 1, -1);
    check_frame("odd40", 40, 24'h028007);

    fill(0, 0);
    send(5, 0, 0, -1);
    check_frame("zero", 0, 24'h000005);

    fill(1600, 0);
    ec = exp_ctrl(1600, 0, 0);
    chk("long.len", ec[23:12], 12'h640);
    chk("long.flag", ec[3], 1);
    send(8, 1600, 0, -1);
    check_frame("long", 1600, ec);

    fill(70, 1);
    send(3, 70, 0, -1);
    idle(4);
    chk("shortpre.nbytes", rxq.size(), 0);
    chk("shortpre.nframe", fq.size(), 0);
    clear_q();
    send(4, 70, 0, -1);
    check_frame("afterdrop", 70, 24'h046000);

    for (int t = 0; t < 14; t++) begin
      n    = $urandom_range(0, 100);
      pre  = $urandom_range(4, 15);
      odd  = $urandom_range(0, 1);
      good = $urandom_range(0, 1);
      fill(n, good);
      en = -1;
      if ($urandom_range(0, 3) == 0 && 2 * n + odd > 0)
        en = $urandom_range(0, 2 * n + odd - 1);
      send(pre, n, odd, en);
      check_frame($sformatf("rnd%0d", t), n,
                  exp_ctrl(n, odd, en >= 0));
    end

    fill(64, 1);
    for (int i = 0; i < 6; i++) drv(1, 0, 4'h5);
    drv(1, 0, 4'hD);
    for (int k = 0; k < 40; k++)
      drv(1, 0, (k % 2) ? tx[k/2][7:4] : tx[k/2][3:0]);
    drv(1, 0, tx[20][3:0]);
    #2 reset = 1'b0;
    #1;
    chk("rstmid.dval", f_data_valid, 0);
    chk("rstmid.data", f_data_out, 0);
    chk("rstmid.ctrl", f_ctrl_out, 0);
    drv(0, 0, 4'h0);
    reset = 1'b1;
    idle(5);
    chk("rstmid.nbytes", rxq.size(), 20);
    chk("rstmid.nframe", fq.size(), 0);
    clear_q();

    fill(64, 1);
    send(7, 64, 0, -1);
    send(7, 64, 0, -1);
    idle(4);
    chk("b2b.nframe", fq.size(), 2);
    chk("b2b.nbytes", rxq.size(), 128);
    chk("b2b.nsof", sofq.size(), 2);
    en = 0;
    for (int i = 0; i < rxq.size(); i++)
      if (rxq[i] !== tx[i % 64]) en++;
    chk("b2b.data", en, 0);
    for (int i = 0; i < fq.size(); i++) begin
      chk("b2b.ctrl", fq[i], 24'h040000);
      chk("b2b.ok", okq[i], 1);
    end
    clear_q();

    $display("[TB] %0d tests run, %0d failed", n_run, n_bad);
    $finish;
  end

endmodule
